// File: rtl/pktin_rr_arbiter.sv
// Purpose: round-robin merge of two AXIS TX requesters onto the FAST UM pktin write port, packet-granular.
// Latency: 1 cycle from accepted beat to pktin_data_wr (plus 1 cycle of grant setup from IDLE).
// Backpressure: pktin_ready gates the owner's tready combinationally; the other requester sees tready=0.
//
// Ports: s0_*/s1_* AXIS requesters; pktin_* registered UM write side (tuser 01 head, 11 body, 10 tail,
// data_valid/_wr strobe with the tail); grant is the one-hot current owner (00 idle).
// Optional build macro ARB_STATS_EN adds per-port tail counters pkt_cnt0/pkt_cnt1.
module pktin_rr_arbiter #(
    parameter int DATA_W = 256,
    parameter int KEEP_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] s0_tdata,
    input  logic [KEEP_W-1:0] s0_tkeep,
    input  logic              s0_tvalid,
    input  logic              s0_tlast,
    output logic              s0_tready,
    input  logic [DATA_W-1:0] s1_tdata,
    input  logic [KEEP_W-1:0] s1_tkeep,
    input  logic              s1_tvalid,
    input  logic              s1_tlast,
    output logic              s1_tready,
    output logic [DATA_W-1:0] pktin_data,
    output logic              pktin_data_wr,
    output logic [KEEP_W-1:0] pktin_tkeep,
    output logic [1:0]        pktin_tuser,
    output logic              pktin_data_valid,
    output logic              pktin_data_valid_wr,
    input  logic              pktin_ready,
`ifdef ARB_STATS_EN
    output logic [CNT_W-1:0]  pkt_cnt0,
    output logic [CNT_W-1:0]  pkt_cnt1,
`endif
    output logic [1:0]        grant
);

    typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

    state_t              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                first_beat_q, first_beat_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [KEEP_W-1:0]   keep_q, keep_d;
    logic                wr_q, wr_d;
    logic [1:0]          tuser_q, tuser_d;
    logic                tail_vld_q, tail_vld_d;

    // Owner-relative view of the two requesters
    logic                own_sel;
    logic                own_vld;
    logic                oth_vld;
    logic                own_last;
    logic                acc;
    state_t              own_state;
    state_t              oth_state;

    always_comb begin
        own_sel   = (state_q == GNT1);
        own_vld   = own_sel ? s1_tvalid : s0_tvalid;
        oth_vld   = own_sel ? s0_tvalid : s1_tvalid;
        own_last  = own_sel ? s1_tlast  : s0_tlast;
        own_state = own_sel ? GNT1 : GNT0;
        oth_state = own_sel ? GNT0 : GNT1;

        s0_tready = (state_q == GNT0) && pktin_ready;
        s1_tready = (state_q == GNT1) && pktin_ready;
        acc       = (state_q != IDLE) && own_vld && pktin_ready;

        state_d      = state_q;
        last_grant_d = last_grant_q;
        first_beat_d = first_beat_q;

        case (state_q)
            IDLE: begin
                first_beat_d = 1'b1;
                if (s0_tvalid && s1_tvalid) state_d = last_grant_q ? GNT0 : GNT1;
                else if (s0_tvalid)         state_d = GNT0;
                else if (s1_tvalid)         state_d = GNT1;
            end
            GNT0, GNT1: begin
                if (acc) begin
                    if (own_last) begin
                        // Tail: re-arbitrate in the same cycle so consecutive packets have no bubble.
                        first_beat_d = 1'b1;
                        last_grant_d = own_sel;
                        if (oth_vld)      state_d = oth_state;
                        else if (own_vld) state_d = own_state;
                        else              state_d = IDLE;
                    end else begin
                        first_beat_d = 1'b0;
                    end
                end else if (first_beat_q && !own_vld) begin
                    // Between packets the owner has gone quiet: release so the other side is not starved.
                    // Mid-packet (first_beat_q low) the grant is held indefinitely.
                    state_d = oth_vld ? oth_state : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        wr_d       = acc;
        data_d     = acc ? (own_sel ? s1_tdata : s0_tdata) : data_q;
        keep_d     = acc ? (own_sel ? s1_tkeep : s0_tkeep) : keep_q;
        tail_vld_d = acc && own_last;
        // Tail overrides head, so a single-beat packet is tagged 10
        if (!acc)              tuser_d = 2'b00;
        else if (own_last)     tuser_d = 2'b10;
        else if (first_beat_q) tuser_d = 2'b01;
        else                   tuser_d = 2'b11;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            first_beat_q <= 1'b1;
            data_q       <= '0;
            keep_q       <= '0;
            wr_q         <= 1'b0;
            tuser_q      <= 2'b00;
            tail_vld_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            first_beat_q <= first_beat_d;
            data_q       <= data_d;
            keep_q       <= keep_d;
            wr_q         <= wr_d;
            tuser_q      <= tuser_d;
            tail_vld_q   <= tail_vld_d;
        end
    end

    assign pktin_data          = data_q;
    assign pktin_tkeep         = keep_q;
    assign pktin_data_wr       = wr_q;
    assign pktin_tuser         = tuser_q;
    assign pktin_data_valid    = tail_vld_q;
    assign pktin_data_valid_wr = tail_vld_q;
    assign grant               = {state_q == GNT1, state_q == GNT0};

`ifdef ARB_STATS_EN
    logic [CNT_W-1:0] pkt_cnt0_q, pkt_cnt0_d;
    logic [CNT_W-1:0] pkt_cnt1_q, pkt_cnt1_d;

    // Counters wrap naturally from all-ones to zero
    always_comb begin
        pkt_cnt0_d = pkt_cnt0_q;
        pkt_cnt1_d = pkt_cnt1_q;
        if (acc && own_last && !own_sel) pkt_cnt0_d = pkt_cnt0_q + CNT_W'(1);
        if (acc && own_last &&  own_sel) pkt_cnt1_d = pkt_cnt1_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_cnt0_q <= '0;
            pkt_cnt1_q <= '0;
        end else begin
            pkt_cnt0_q <= pkt_cnt0_d;
            pkt_cnt1_q <= pkt_cnt1_d;
        end
    end

    assign pkt_cnt0 = pkt_cnt0_q;
    assign pkt_cnt1 = pkt_cnt1_q;
`endif

endmodule

// File: tb/tb_pktin_rr_arbiter.sv
// Testbench for pktin_rr_arbiter: directed scenarios plus randomized traffic against a packet-queue model.
// Beats carry their port, packet id and beat index in the top data bits so the output stream is self-describing.
module tb_pktin_rr_arbiter;
    localparam int DATA_W = 256;
    localparam int KEEP_W = 32;
    localparam int CNT_W  = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [DATA_W-1:0] s0_tdata = '0, s1_tdata = '0;
    logic [KEEP_W-1:0] s0_tkeep = '0, s1_tkeep = '0;
    logic              s0_tvalid = 1'b0, s1_tvalid = 1'b0;
    logic              s0_tlast = 1'b0, s1_tlast = 1'b0;
    logic              s0_tready, s1_tready;
    logic [DATA_W-1:0] pktin_data;
    logic              pktin_data_wr;
    logic [KEEP_W-1:0] pktin_tkeep;
    logic [1:0]        pktin_tuser;
    logic              pktin_data_valid, pktin_data_valid_wr;
    logic              pktin_ready = 1'b0;
    logic [1:0]        grant;
`ifdef ARB_STATS_EN
    logic [CNT_W-1:0]  pkt_cnt0, pkt_cnt1;
`endif

    always #5 clk = ~clk;

    pktin_rr_arbiter #(.DATA_W(DATA_W), .KEEP_W(KEEP_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .s0_tdata(s0_tdata), .s0_tkeep(s0_tkeep), .s0_tvalid(s0_tvalid), .s0_tlast(s0_tlast), .s0_tready(s0_tready),
        .s1_tdata(s1_tdata), .s1_tkeep(s1_tkeep), .s1_tvalid(s1_tvalid), .s1_tlast(s1_tlast), .s1_tready(s1_tready),
        .pktin_data(pktin_data), .pktin_data_wr(pktin_data_wr), .pktin_tkeep(pktin_tkeep),
        .pktin_tuser(pktin_tuser), .pktin_data_valid(pktin_data_valid),
        .pktin_data_valid_wr(pktin_data_valid_wr), .pktin_ready(pktin_ready),
`ifdef ARB_STATS_EN
        .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1),
`endif
        .grant(grant)
    );

    int n_vec = 0;
    int n_err = 0;
    int pkt_id = 0;

    // Source model: per-port queues of pending beats
    logic [DATA_W-1:0] q_dat0[$], q_dat1[$];
    logic [KEEP_W-1:0] q_keep0[$], q_keep1[$];
    logic              q_last0[$], q_last1[$];
    int                pos0 = 0, pos1 = 0;

    // Per-step observations and model expectations
    logic              acc0, acc1, rdy0_obs, rdy1_obs;
    logic [1:0]        grant_obs;
    logic              exp_wr, exp_dv;
    logic [DATA_W-1:0] exp_dat;
    logic [KEEP_W-1:0] exp_keep;
    logic [1:0]        exp_tuser;
    logic              obs_wr, obs_dv, obs_dvwr;
    logic [DATA_W-1:0] obs_dat;
    logic [KEEP_W-1:0] obs_keep;
    logic [1:0]        obs_tuser, obs_grant;

    function automatic logic [DATA_W-1:0] mk_beat(input int port, input int idx);
        logic [DATA_W-1:0] d;
        for (int i = 0; i < DATA_W / 32; i++) d[i*32 +: 32] = $urandom;
        d[255:248] = 8'(port);
        d[247:232] = 16'(pkt_id);
        d[231:224] = 8'(idx);
        return d;
    endfunction

    task automatic push_pkt(input int port, input int len);
        pkt_id++;
        for (int i = 0; i < len; i++) begin
            if (port == 0) begin
                q_dat0.push_back(mk_beat(0, i)); q_keep0.push_back(KEEP_W'($urandom)); q_last0.push_back(i == len - 1);
            end else begin
                q_dat1.push_back(mk_beat(1, i)); q_keep1.push_back(KEEP_W'($urandom)); q_last1.push_back(i == len - 1);
            end
        end
    endtask

    task automatic flush_src();
        q_dat0.delete(); q_keep0.delete(); q_last0.delete();
        q_dat1.delete(); q_keep1.delete(); q_last1.delete();
        s0_tvalid = 1'b0; s1_tvalid = 1'b0;
        pos0 = 0; pos1 = 0;
    endtask

    task automatic do_reset();
        flush_src();
        pktin_ready = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // One clock: drive at negedge, note the handshake, observe outputs 1ns after posedge.
    // Expected output follows from the accepted queue head; the tag follows from its position in its packet.
    task automatic step(input bit rdy, input bit en0, input bit en1);
        pktin_ready = rdy;
        if (!s0_tvalid) s0_tvalid = en0 && (q_dat0.size() > 0);
        if (!s1_tvalid) s1_tvalid = en1 && (q_dat1.size() > 0);
        if (s0_tvalid) begin s0_tdata = q_dat0[0]; s0_tkeep = q_keep0[0]; s0_tlast = q_last0[0]; end
        if (s1_tvalid) begin s1_tdata = q_dat1[0]; s1_tkeep = q_keep1[0]; s1_tlast = q_last1[0]; end
        #1;
        rdy0_obs = s0_tready; rdy1_obs = s1_tready; grant_obs = grant;
        acc0 = s0_tvalid && s0_tready;
        acc1 = s1_tvalid && s1_tready;
        exp_wr = acc0 || acc1; exp_dv = 1'b0; exp_tuser = 2'b00; exp_dat = '0; exp_keep = '0;
        if (acc0) begin
            exp_dat = q_dat0[0]; exp_keep = q_keep0[0]; exp_dv = q_last0[0];
            exp_tuser = q_last0[0] ? 2'b10 : (pos0 == 0 ? 2'b01 : 2'b11);
            pos0 = q_last0[0] ? 0 : pos0 + 1;
        end else if (acc1) begin
            exp_dat = q_dat1[0]; exp_keep = q_keep1[0]; exp_dv = q_last1[0];
            exp_tuser = q_last1[0] ? 2'b10 : (pos1 == 0 ? 2'b01 : 2'b11);
            pos1 = q_last1[0] ? 0 : pos1 + 1;
        end
        @(posedge clk); #1;
        obs_wr = pktin_data_wr; obs_dat = pktin_data; obs_keep = pktin_tkeep; obs_tuser = pktin_tuser;
        obs_dv = pktin_data_valid; obs_dvwr = pktin_data_valid_wr; obs_grant = grant;
        if (acc0) begin void'(q_dat0.pop_front()); void'(q_keep0.pop_front()); void'(q_last0.pop_front()); s0_tvalid = 1'b0; end
        if (acc1) begin void'(q_dat1.pop_front()); void'(q_keep1.pop_front()); void'(q_last1.pop_front()); s1_tvalid = 1'b0; end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pktin_ready = 1'b1;
        s0_tvalid = 1'b1; s1_tvalid = 1'b1;
        @(negedge clk);
        n_vec++;
        if ({pktin_data_wr, pktin_tuser, pktin_data_valid, pktin_data_valid_wr, grant, s0_tready, s1_tready} !== 9'd0) begin
            n_err++;
            $display("FAIL reset_ctrl got wr=%b tuser=%b dv=%b dvwr=%b grant=%b rdy=%b%b want all 0",
                     pktin_data_wr, pktin_tuser, pktin_data_valid, pktin_data_valid_wr, grant, s0_tready, s1_tready);
        end
        n_vec++;
        if (pktin_data !== '0 || pktin_tkeep !== '0) begin
            n_err++; $display("FAIL reset_data got data=%h keep=%h want 0", pktin_data, pktin_tkeep);
        end
        do_reset();
    endtask

    task automatic test_single_port();
        int first_wr, nwr;
        logic [1:0] tags[3];
        logic [2:0] dvs;
        do_reset();
        push_pkt(0, 3);
        first_wr = -1; nwr = 0; dvs = '0;
        for (int c = 1; c <= 8; c++) begin
            step(1'b1, 1'b1, 1'b0);
            if (obs_wr) begin
                if (first_wr < 0) first_wr = c;
                n_vec++;
                if (obs_dat !== exp_dat || obs_keep !== exp_keep) begin
                    n_err++; $display("FAIL single_beat%0d got %h want %h", nwr, obs_dat[255:224], exp_dat[255:224]);
                end
                if (nwr < 3) begin tags[nwr] = obs_tuser; dvs[nwr] = obs_dv & obs_dvwr; end
                nwr++;
            end
        end
        n_vec++;
        if (first_wr != 2) begin n_err++; $display("FAIL single_latency got %0d want 2", first_wr); end
        n_vec++;
        if (nwr != 3) begin n_err++; $display("FAIL single_count got %0d want 3", nwr); end
        n_vec++;
        if ({tags[0], tags[1], tags[2]} !== 6'b01_11_10) begin
            n_err++; $display("FAIL single_tags got %b %b %b want 01 11 10", tags[0], tags[1], tags[2]);
        end
        n_vec++;
        if (dvs !== 3'b100) begin n_err++; $display("FAIL single_valid got %b want 100", dvs); end
    endtask

    task automatic test_back_to_back();
        int nwr, first_wr, last_wr;
        logic [7:0] ports[8];
        do_reset();
        push_pkt(0, 2); push_pkt(1, 2); push_pkt(0, 2); push_pkt(1, 2);
        nwr = 0; first_wr = -1; last_wr = -1;
        for (int c = 1; c <= 14; c++) begin
            step(1'b1, 1'b1, 1'b1);
            n_vec++;
            if (rdy0_obs && rdy1_obs) begin n_err++; $display("FAIL b2b_both_ready got 11 want one-hot"); end
            if (obs_wr) begin
                if (first_wr < 0) first_wr = c;
                last_wr = c;
                if (nwr < 8) ports[nwr] = obs_dat[255:248];
                nwr++;
            end
        end
        n_vec++;
        if (nwr != 8 || last_wr - first_wr != 7) begin
            n_err++; $display("FAIL b2b_gapless got %0d beats over %0d cycles want 8 over 8", nwr, last_wr - first_wr + 1);
        end
        n_vec++;
        if ({ports[0][0], ports[1][0], ports[2][0], ports[3][0], ports[4][0], ports[5][0], ports[6][0], ports[7][0]} !== 8'b00110011) begin
            n_err++; $display("FAIL b2b_order got %0d%0d%0d%0d%0d%0d%0d%0d want 00110011",
                ports[0], ports[1], ports[2], ports[3], ports[4], ports[5], ports[6], ports[7]);
        end
    endtask

    task automatic test_single_beat_stream();
        int nwr, first_wr, last_wr;
        do_reset();
        for (int i = 0; i < 6; i++) push_pkt(1, 1);
        nwr = 0; first_wr = -1; last_wr = -1;
        for (int c = 1; c <= 10; c++) begin
            step(1'b1, 1'b0, 1'b1);
            if (obs_wr) begin
                if (first_wr < 0) first_wr = c;
                last_wr = c; nwr++;
                n_vec++;
                if (obs_tuser !== 2'b10 || !obs_dv || !obs_dvwr || obs_dat !== exp_dat) begin
                    n_err++; $display("FAIL sbeat_tag got tuser=%b dv=%b dvwr=%b want 10 1 1", obs_tuser, obs_dv, obs_dvwr);
                end
            end
        end
        n_vec++;
        if (nwr != 6 || last_wr - first_wr != 5) begin
            n_err++; $display("FAIL sbeat_rate got %0d beats over %0d cycles want 6 over 6", nwr, last_wr - first_wr + 1);
        end
    endtask

    task automatic test_backpressure();
        int nwr, guard;
        logic [1:0] tags[4];
        logic [7:0] idx[4];
        do_reset();
        push_pkt(0, 4);
        nwr = 0; guard = 0;
        while (nwr == 0 && guard < 10) begin
            step(1'b1, 1'b1, 1'b0); guard++;
            if (obs_wr) begin tags[0] = obs_tuser; idx[0] = obs_dat[231:224]; nwr = 1; end
        end
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 1'b1, 1'b0);
            n_vec++;
            if (rdy0_obs !== 1'b0 || obs_wr !== 1'b0 || obs_grant !== 2'b01) begin
                n_err++; $display("FAIL bp_stall got tready=%b wr=%b grant=%b want 0 0 01", rdy0_obs, obs_wr, obs_grant);
            end
        end
        for (int c = 0; c < 8; c++) begin
            step(1'b1, 1'b1, 1'b0);
            if (obs_wr) begin
                if (nwr < 4) begin tags[nwr] = obs_tuser; idx[nwr] = obs_dat[231:224]; end
                nwr++;
            end
        end
        n_vec++;
        if (nwr != 4) begin n_err++; $display("FAIL bp_count got %0d want 4", nwr); end
        else begin
            n_vec++;
            if ({tags[0], tags[1], tags[2], tags[3]} !== 8'b01_11_11_10) begin
                n_err++; $display("FAIL bp_tags got %b %b %b %b want 01 11 11 10", tags[0], tags[1], tags[2], tags[3]);
            end
            n_vec++;
            if ({idx[0], idx[1], idx[2], idx[3]} !== {8'd0, 8'd1, 8'd2, 8'd3}) begin
                n_err++; $display("FAIL bp_beats got %0d %0d %0d %0d want 0 1 2 3", idx[0], idx[1], idx[2], idx[3]);
            end
        end
    endtask

    task automatic test_reset_mid_packet();
        int guard;
        logic got;
        do_reset();
        push_pkt(0, 3);
        guard = 0; got = 1'b0;
        while (!got && guard < 10) begin step(1'b1, 1'b1, 1'b0); guard++; got = obs_wr; end
        // Beat 2 is on the bus; yank reset asynchronously
        pktin_ready = 1'b1;
        if (!s0_tvalid) s0_tvalid = 1'b1;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if ({pktin_data_wr, pktin_tuser, pktin_data_valid, pktin_data_valid_wr, grant, s0_tready} !== 8'd0 ||
            pktin_data !== '0) begin
            n_err++; $display("FAIL rstmid_outputs got wr=%b tuser=%b grant=%b tready=%b want all 0",
                              pktin_data_wr, pktin_tuser, grant, s0_tready);
        end
        @(negedge clk);
        flush_src();
        rst_n = 1'b1;
        @(negedge clk);
        push_pkt(0, 2);
        guard = 0; got = 1'b0;
        while (!got && guard < 10) begin step(1'b1, 1'b1, 1'b0); guard++; got = obs_wr; end
        n_vec++;
        if (!got || obs_tuser !== 2'b01 || obs_dat[231:224] !== 8'd0) begin
            n_err++; $display("FAIL rstmid_head got wr=%b tuser=%b idx=%0d want 1 01 0", got, obs_tuser, obs_dat[231:224]);
        end
        repeat (3) step(1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        int owner, guard;
        do_reset();
        owner = -1;
        for (int c = 0; c < 1200; c++) begin
            if (c < 900) begin
                if (q_dat0.size() < 6) push_pkt(0, $urandom_range(1, 4));
                if (q_dat1.size() < 6) push_pkt(1, $urandom_range(1, 4));
            end
            step(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 7), ($urandom_range(0, 9) < 6));
            n_vec++;
            if ((rdy0_obs && rdy1_obs) || ((rdy0_obs || rdy1_obs) && !pktin_ready)) begin
                n_err++; $display("FAIL rnd_tready got %b%b ready=%b", rdy0_obs, rdy1_obs, pktin_ready);
            end
            n_vec++;
            if (obs_wr !== exp_wr) begin
                n_err++; $display("FAIL rnd_wr cycle %0d got %b want %b", c, obs_wr, exp_wr);
            end else if (exp_wr) begin
                n_vec++;
                if (obs_dat !== exp_dat || obs_keep !== exp_keep || obs_tuser !== exp_tuser ||
                    obs_dv !== exp_dv || obs_dvwr !== exp_dv) begin
                    n_err++; $display("FAIL rnd_beat cycle %0d got %h/%b/%b want %h/%b/%b", c, obs_dat[255:224],
                                      obs_tuser, obs_dv, exp_dat[255:224], exp_tuser, exp_dv);
                end
                n_vec++;
                if (owner >= 0 && int'(obs_dat[255:248]) != owner) begin
                    n_err++; $display("FAIL rnd_interleave got port %0d want %0d", obs_dat[255:248], owner);
                end
                owner = exp_dv ? -1 : int'(exp_dat[255:248]);
            end else begin
                n_vec++;
                if (obs_dv !== 1'b0 || obs_dvwr !== 1'b0) begin
                    n_err++; $display("FAIL rnd_idle_valid got %b%b want 00", obs_dv, obs_dvwr);
                end
            end
            if (c >= 900 && q_dat0.size() == 0 && q_dat1.size() == 0 && !s0_tvalid && !s1_tvalid) break;
        end
        guard = 0;
        while ((q_dat0.size() != 0 || q_dat1.size() != 0) && guard < 200) begin step(1'b1, 1'b1, 1'b1); guard++; end
        n_vec++;
        if (q_dat0.size() != 0 || q_dat1.size() != 0) begin
            n_err++; $display("FAIL rnd_drain got %0d/%0d beats left want 0/0", q_dat0.size(), q_dat1.size());
        end
    endtask

`ifdef ARB_STATS_EN
    task automatic test_stats();
        int guard;
        do_reset();
        for (int i = 0; i < 5; i++) push_pkt(0, $urandom_range(1, 3));
        for (int i = 0; i < 3; i++) push_pkt(1, $urandom_range(1, 3));
        guard = 0;
        while ((q_dat0.size() != 0 || q_dat1.size() != 0) && guard < 200) begin
            step(($urandom_range(0, 3) != 0), 1'b1, 1'b1); guard++;
        end
        repeat (3) step(1'b1, 1'b0, 1'b0);
        n_vec++;
        if (pkt_cnt0 !== CNT_W'(5) || pkt_cnt1 !== CNT_W'(3)) begin
            n_err++; $display("FAIL stats_count got %0d/%0d want 5/3", pkt_cnt0, pkt_cnt1);
        end
        force dut.pkt_cnt0_q = '1;
        #1;
        release dut.pkt_cnt0_q;
        @(negedge clk);
        push_pkt(0, 2);
        guard = 0;
        while (q_dat0.size() != 0 && guard < 20) begin step(1'b1, 1'b1, 1'b0); guard++; end
        step(1'b1, 1'b0, 1'b0);
        n_vec++;
        if (pkt_cnt0 !== '0 || pkt_cnt1 !== CNT_W'(3)) begin
            n_err++; $display("FAIL stats_wrap got %0d/%0d want 0/3", pkt_cnt0, pkt_cnt1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_port();
        test_back_to_back();
        test_single_beat_stream();
        test_backpressure();
        test_reset_mid_packet();
        test_random();
`ifdef ARB_STATS_EN
        test_stats();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
